// File: rtl/prio_arbiter4_pkg.sv
// Shared definitions for the four-requester priority arbiter.
//
// Contents:
//   state_t       - arbiter FSM encoding (IDLE / GRANT / RECOVER)
//   ID_NONE       - encoded owner value meaning "no owner"
//   NREQ          - number of requesters
//   id_to_onehot  - converts an encoded owner id (1..4) to a one-hot [4:1]
//                   vector; any other code yields all-zero
package prio_arbiter4_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RECOVER = 2'b10
  } state_t;

  localparam logic [2:0] ID_NONE = 3'b000;
  localparam int         NREQ    = 4;

  function automatic logic [4:1] id_to_onehot(input logic [2:0] id);
    logic [4:1] oh;
    oh = '0;
    case (id)
      3'd1:    oh = 4'b0001;
      3'd2:    oh = 4'b0010;
      3'd3:    oh = 4'b0100;
      3'd4:    oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/prio_arbiter4_pick.sv
// Combinational 4-to-3 priority pick used by the arbiter FSM.
//
// Ports:
//   req   [4:1] in   request lines
//   mask  [4:1] in   requesters excluded from this pick (1 = excluded)
//   start [2:0] in   last owner id; round-robin scan begins at start+1
//   rr          in   0 = fixed priority (4 highest), 1 = round-robin
//   valid       out  at least one eligible request
//   id    [2:0] out  winning requester 1..4, ID_NONE when !valid
module arb_pick4
  import prio_arbiter4_pkg::*;
(
  input  logic [4:1] req,
  input  logic [4:1] mask,
  input  logic [2:0] start,
  input  logic       rr,
  output logic       valid,
  output logic [2:0] id
);

  logic [4:1] elig;
  logic [2:0] cand;
  logic       found;

  assign elig  = req & ~mask;
  assign valid = |elig;

  always_comb begin
    id    = ID_NONE;
    cand  = ID_NONE;
    found = 1'b0;
    if (rr) begin
      // Scan start+1, start+2, ... wrapping 4 -> 1. start=0 (no previous
      // owner) and start=4 both begin the scan at requester 1.
      for (int k = 0; k < NREQ; k++) begin
        cand = 3'(((int'(start) + k) % NREQ) + 1);
        if (!found && elig[cand]) begin
          found = 1'b1;
          id    = cand;
        end
      end
    end else begin
      // Ascending scan, later hits overwrite: highest index wins.
      for (int k = 1; k <= NREQ; k++) begin
        if (elig[k]) begin
          id = 3'(k);
        end
      end
    end
  end

endmodule

// File: rtl/prio_arbiter4.sv
// Four-requester arbiter with registered grants.
//
// An owner keeps the resource until it drops its request. If MAX_HOLD is
// non-zero and the owner has held for MAX_HOLD cycles while someone else is
// waiting, it is forcibly released (preempt pulse) and excluded from the
// very next pick. Every release passes through one dead RECOVER cycle.
//
// Parameters:
//   RR        0 = fixed priority (4 > 3 > 2 > 1), 1 = round-robin
//   MAX_HOLD  grant cycles before preemption when contended; 0 = never
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous reset, active-low
//   req  [4:1] in   level-sensitive request lines
//   gnt  [4:1] out  registered one-hot grant, zero when no owner
//   gnt_id[2:0]out  encoded owner, 0 = none, 1..4 = requester
//   busy       out  high while in GRANT
//   preempt    out  one-cycle pulse in the cycle after a timeout release
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: req is a level; a requester owns the resource for every cycle
// its gnt bit is high and releases it by deasserting req, which takes
// effect at the next clock edge (gnt low one cycle later).
module prio_arbiter4
  import prio_arbiter4_pkg::*;
#(
  parameter int RR       = 0,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:1] req,
  output logic [4:1] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       preempt,
  output state_t     dbg_state
);

  localparam int HW_RAW = $clog2(MAX_HOLD + 1);
  localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;
  // Counter value reached in the last allowed cycle of a contended grant.
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic          RR_BIT    = (RR != 0);
  localparam logic          TO_EN     = (MAX_HOLD != 0);

  state_t        state_q,   state_d;
  logic [2:0]    gnt_id_q,  gnt_id_d;
  logic [2:0]    last_id_q, last_id_d;
  logic [2:0]    excl_q,    excl_d;
  logic [HW-1:0] hold_q,    hold_d;
  logic          preempt_q, preempt_d;
  logic [4:1]    gnt_q;
  logic          busy_q;

  logic [4:1] pick_mask;
  logic       pick_valid;
  logic [2:0] pick_id;
  logic       owner_req;
  logic       others_req;

  // The excluded requester only matters for the RECOVER pick; outside
  // RECOVER excl_q is always ID_NONE, so the mask is all-zero anyway.
  assign pick_mask = (state_q == RECOVER) ? id_to_onehot(excl_q) : '0;

  arb_pick4 u_pick (
    .req   (req),
    .mask  (pick_mask),
    .start (last_id_q),
    .rr    (RR_BIT),
    .valid (pick_valid),
    .id    (pick_id)
  );

  assign owner_req  = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    excl_d    = excl_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_id_d = ID_NONE;
        if (pick_valid) begin
          state_d   = GRANT;
          gnt_id_d  = pick_id;
          last_id_d = pick_id;
          hold_d    = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Voluntary release: nobody is excluded afterwards.
          state_d  = RECOVER;
          gnt_id_d = ID_NONE;
          excl_d   = ID_NONE;
        end else if (TO_EN && (hold_q == HOLD_LAST) && others_req) begin
          state_d   = RECOVER;
          gnt_id_d  = ID_NONE;
          excl_d    = gnt_id_q;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          // Saturates so a lone owner can be preempted the moment a
          // competitor shows up after a long solo hold.
          hold_d = hold_q + 1'b1;
        end
      end
      RECOVER: begin
        excl_d   = ID_NONE;
        gnt_id_d = ID_NONE;
        state_d  = IDLE;
        if (pick_valid) begin
          state_d   = GRANT;
          gnt_id_d  = pick_id;
          last_id_d = pick_id;
          hold_d    = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_id_d = ID_NONE;
        excl_d   = ID_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_id_q  <= ID_NONE;
      last_id_q <= ID_NONE;
      excl_q    <= ID_NONE;
      hold_q    <= '0;
      preempt_q <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      excl_q    <= excl_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
      gnt_q     <= id_to_onehot(gnt_id_d);
      busy_q    <= (state_d == GRANT);
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign preempt   = preempt_q;
  assign dbg_state = state_q;

endmodule
